// File: rtl/bpred_btb_if.sv
// Fetch/execute-facing signal bundle for the BTB branch predictor.
// The master side is the pipeline (fetch PC plus execute resolution); the slave side is the predictor.
interface bpred_btb_if #(
    parameter int ADDR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0] f_pc;
    logic                  f_pred_taken;
    logic [ADDR_WIDTH-1:0] f_pred_target;
    logic                  flush_all;
    logic                  upd_valid;
    logic [ADDR_WIDTH-1:0] upd_pc;
    logic                  upd_uncond;
    logic                  upd_taken;
    logic [ADDR_WIDTH-1:0] upd_target;
    logic                  upd_mispredict;
    logic [31:0]           stat_mispredicts;

    modport master (
        output f_pc,
        output flush_all,
        output upd_valid,
        output upd_pc,
        output upd_uncond,
        output upd_taken,
        output upd_target,
        output upd_mispredict,
        input  f_pred_taken,
        input  f_pred_target,
        input  stat_mispredicts
    );

    modport slave (
        input  f_pc,
        input  flush_all,
        input  upd_valid,
        input  upd_pc,
        input  upd_uncond,
        input  upd_taken,
        input  upd_target,
        input  upd_mispredict,
        output f_pred_taken,
        output f_pred_target,
        output stat_mispredicts
    );
endinterface

// File: rtl/bpred_btb.sv
// Direct-mapped branch target buffer with a per-entry saturating direction counter.
// Lookup is combinational from registered state; execute trains one entry per cycle.
module bpred_btb #(
    parameter int ADDR_WIDTH = 32,
    parameter int ENTRIES    = 64,
    parameter int CTR_BITS   = 2
) (
    input logic        clk,
    input logic        rst,
    bpred_btb_if.slave bus
);
    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = ADDR_WIDTH - 2 - IDX_W;

    localparam logic [CTR_BITS-1:0] CTR_MAX  = '1;
    localparam logic [CTR_BITS-1:0] CTR_ZERO = '0;
    localparam logic [CTR_BITS-1:0] CTR_ONE  = CTR_BITS'(1);
    localparam logic [CTR_BITS-1:0] CTR_WEAK = CTR_ONE << (CTR_BITS - 1);

    logic [ENTRIES-1:0]    r_valid;
    logic [TAG_W-1:0]      r_tag    [ENTRIES];
    logic [ADDR_WIDTH-1:0] r_target [ENTRIES];
    logic [CTR_BITS-1:0]   r_ctr    [ENTRIES];
    logic [31:0]           r_statMispredicts;

    logic [IDX_W-1:0]      w_fIdx;
    logic [TAG_W-1:0]      w_fTag;
    logic                  w_fHit;
    logic                  w_fTaken;
    logic [ADDR_WIDTH-1:0] w_fSeqPc;

    logic [IDX_W-1:0]      w_uIdx;
    logic [TAG_W-1:0]      w_uTag;
    logic                  w_uHit;
    logic                  w_doUpd;
    logic                  w_alloc;
    logic                  w_ctrWrite;
    logic                  w_tgtWrite;
    logic [CTR_BITS-1:0]   w_ctrCur;
    logic [CTR_BITS-1:0]   w_ctrNext;

    // Fetch-side lookup sees only registered state, so a same-cycle update is not bypassed.
    assign w_fIdx   = bus.f_pc[IDX_W+1:2];
    assign w_fTag   = bus.f_pc[ADDR_WIDTH-1:IDX_W+2];
    assign w_fHit   = r_valid[w_fIdx] && (r_tag[w_fIdx] == w_fTag);
    assign w_fTaken = w_fHit && r_ctr[w_fIdx][CTR_BITS-1];
    assign w_fSeqPc = bus.f_pc + ADDR_WIDTH'(4);

    assign bus.f_pred_taken     = w_fTaken;
    assign bus.f_pred_target    = w_fTaken ? r_target[w_fIdx] : w_fSeqPc;
    assign bus.stat_mispredicts = r_statMispredicts;

    assign w_uIdx  = bus.upd_pc[IDX_W+1:2];
    assign w_uTag  = bus.upd_pc[ADDR_WIDTH-1:IDX_W+2];
    assign w_uHit  = r_valid[w_uIdx] && (r_tag[w_uIdx] == w_uTag);
    assign w_doUpd = bus.upd_valid && !bus.flush_all;

    // A not-taken miss leaves the table alone; everything else touches the counter.
    assign w_alloc    = w_doUpd && !w_uHit && bus.upd_taken;
    assign w_ctrWrite = w_doUpd && (w_uHit || bus.upd_taken);
    assign w_tgtWrite = w_doUpd && (bus.upd_taken || (w_uHit && bus.upd_uncond));

    always_comb begin
        w_ctrCur  = r_ctr[w_uIdx];
        w_ctrNext = w_ctrCur;
        if (!w_uHit) begin
            w_ctrNext = bus.upd_uncond ? CTR_MAX : CTR_WEAK;
        end else if (bus.upd_uncond) begin
            w_ctrNext = CTR_MAX;
        end else if (bus.upd_taken) begin
            if (w_ctrCur != CTR_MAX) begin
                w_ctrNext = w_ctrCur + CTR_ONE;
            end
        end else if (w_ctrCur != CTR_ZERO) begin
            w_ctrNext = w_ctrCur - CTR_ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid <= '0;
            for (int i = 0; i < ENTRIES; i++) begin
                r_ctr[i] <= '0;
            end
        end else begin
            if (bus.flush_all) begin
                r_valid <= '0;
            end else if (w_alloc) begin
                r_valid[w_uIdx] <= 1'b1;
            end
            if (w_ctrWrite) begin
                r_ctr[w_uIdx] <= w_ctrNext;
            end
        end
    end

    // Tag and target are only meaningful behind a valid bit, so they carry no reset.
    always_ff @(posedge clk) begin
        if (w_alloc) begin
            r_tag[w_uIdx] <= w_uTag;
        end
        if (w_tgtWrite) begin
            r_target[w_uIdx] <= bus.upd_target;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_statMispredicts <= '0;
        end else if (bus.upd_valid && bus.upd_mispredict) begin
            r_statMispredicts <= r_statMispredicts + 32'd1;
        end
    end
endmodule

// File: tb/tb_bpred_btb.sv
// Directed bench for bpred_btb: expectations are queued as each step is driven and drained against the outputs.
module tb_bpred_btb;
    logic clk;
    logic rst;

    bpred_btb_if #(.ADDR_WIDTH(32)) bus ();

    bpred_btb #(
        .ADDR_WIDTH(32),
        .ENTRIES   (64),
        .CTR_BITS  (2)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus.slave)
    );

    typedef struct {
        string       name;
        int          sel;
        logic [31:0] exp;
    } expT;

    expT  sbQ[$];
    int   testCount = 0;
    int   failCount = 0;
    logic [31:0] expStat = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic applyStimulus(input logic [31:0] pc, input logic flush, input logic uv,
                                 input logic [31:0] upc, input logic unc, input logic tk,
                                 input logic [31:0] tgt, input logic misp);
        @(negedge clk);
        bus.f_pc           = pc;
        bus.flush_all      = flush;
        bus.upd_valid      = uv;
        bus.upd_pc         = upc;
        bus.upd_uncond     = unc;
        bus.upd_taken      = tk;
        bus.upd_target     = tgt;
        bus.upd_mispredict = misp;
    endtask

    task automatic checkOutput();
        expT         e;
        logic [31:0] obs;
        #2;
        while (sbQ.size() > 0) begin
            e = sbQ.pop_front();
            case (e.sel)
                0:       obs = {31'b0, bus.f_pred_taken};
                1:       obs = bus.f_pred_target;
                default: obs = bus.stat_mispredicts;
            endcase
            testCount++;
            assert (obs === e.exp) else begin
                failCount++;
                $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", e.name, obs, e.exp);
            end
        end
    endtask

    // One clock of stimulus: outputs are checked before the edge, so they reflect pre-update state.
    task automatic step(input string name, input logic [31:0] pc, input logic flush, input logic uv,
                        input logic [31:0] upc, input logic unc, input logic tk,
                        input logic [31:0] tgt, input logic misp,
                        input logic expTaken, input logic [31:0] expTarget);
        applyStimulus(pc, flush, uv, upc, unc, tk, tgt, misp);
        sbQ.push_back('{{name, ".taken"},  0, {31'b0, expTaken}});
        sbQ.push_back('{{name, ".target"}, 1, expTarget});
        sbQ.push_back('{{name, ".stat"},   2, expStat});
        checkOutput();
        @(posedge clk);
        if (uv && misp) expStat = expStat + 32'd1;
    endtask

    task automatic lookup(input string name, input logic [31:0] pc,
                          input logic expTaken, input logic [31:0] expTarget);
        step(name, pc, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0, expTaken, expTarget);
    endtask

    task automatic doReset();
        @(negedge clk);
        rst = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        expStat = 0;
    endtask

    initial begin
        rst = 1'b1;
        applyStimulus(32'h0, 1'b0, 1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 1'b0);
        doReset();

        lookup("reset_lookup", 32'h0100_0010, 1'b0, 32'h0100_0014);

        // Allocation, with a same-cycle lookup that must not see the new entry.
        step("alloc_same_cycle", 32'h0100_0010, 1'b0, 1'b1, 32'h0100_0010, 1'b0, 1'b1, 32'h0100_0000, 1'b1,
             1'b0, 32'h0100_0014);
        lookup("alloc_hit", 32'h0100_0010, 1'b1, 32'h0100_0000);

        // Three taken reports from weakly-taken: 2 -> 3 -> 3 -> 3.
        for (int i = 0; i < 3; i++) begin
            step($sformatf("taken_train%0d", i), 32'h0100_0010, 1'b0, 1'b1, 32'h0100_0010, 1'b0, 1'b1,
                 32'h0100_0000, 1'b0, 1'b1, 32'h0100_0000);
        end
        step("nt_from_sat", 32'h0100_0010, 1'b0, 1'b1, 32'h0100_0010, 1'b0, 1'b0, 32'h0, 1'b1,
             1'b1, 32'h0100_0000);
        step("nt_from_2", 32'h0100_0010, 1'b0, 1'b1, 32'h0100_0010, 1'b0, 1'b0, 32'h0, 1'b1,
             1'b1, 32'h0100_0000);
        lookup("ctr1_not_taken", 32'h0100_0010, 1'b0, 32'h0100_0014);

        // Retrain to weakly taken, then evict with an alias at the same index.
        step("retrain", 32'h0100_0010, 1'b0, 1'b1, 32'h0100_0010, 1'b0, 1'b1, 32'h0100_0000, 1'b0,
             1'b0, 32'h0100_0014);
        lookup("retrained_hit", 32'h0100_0010, 1'b1, 32'h0100_0000);
        step("alias_alloc", 32'h0100_0010, 1'b0, 1'b1, 32'h0100_0110, 1'b0, 1'b1, 32'h0100_0200, 1'b1,
             1'b1, 32'h0100_0000);
        lookup("alias_old_miss", 32'h0100_0010, 1'b0, 32'h0100_0014);
        lookup("alias_new_hit", 32'h0100_0110, 1'b1, 32'h0100_0200);

        // Unconditional allocate lands strongly taken and survives one not-taken report.
        step("jalr_alloc", 32'h0100_0020, 1'b0, 1'b1, 32'h0100_0020, 1'b1, 1'b1, 32'h0100_0400, 1'b1,
             1'b0, 32'h0100_0024);
        step("jalr_nt_report", 32'h0100_0020, 1'b0, 1'b1, 32'h0100_0020, 1'b0, 1'b0, 32'h0, 1'b1,
             1'b1, 32'h0100_0400);
        lookup("jalr_still_taken", 32'h0100_0020, 1'b1, 32'h0100_0400);

        // A not-taken miss must not allocate.
        step("nt_miss", 32'h0100_0030, 1'b0, 1'b1, 32'h0100_0030, 1'b0, 1'b0, 32'h0100_0900, 1'b0,
             1'b0, 32'h0100_0034);
        lookup("nt_miss_after", 32'h0100_0030, 1'b0, 32'h0100_0034);

        lookup("pc_wrap", 32'hFFFF_FFFC, 1'b0, 32'h0000_0000);

        // Flush beats a same-cycle allocate, but the mispredict still counts.
        step("flush_with_upd", 32'h0100_0110, 1'b1, 1'b1, 32'h0100_0040, 1'b0, 1'b1, 32'h0100_0800, 1'b1,
             1'b1, 32'h0100_0200);
        lookup("flush_alias_miss", 32'h0100_0110, 1'b0, 32'h0100_0114);
        lookup("flush_upd_dropped", 32'h0100_0040, 1'b0, 32'h0100_0044);
        lookup("flush_jalr_miss", 32'h0100_0020, 1'b0, 32'h0100_0024);

        // Reset mid-training discards entries and the mispredict count.
        step("pre_reset_alloc", 32'h0100_0050, 1'b0, 1'b1, 32'h0100_0050, 1'b1, 1'b1, 32'h0100_0600, 1'b1,
             1'b0, 32'h0100_0054);
        lookup("pre_reset_hit", 32'h0100_0050, 1'b1, 32'h0100_0600);
        doReset();
        lookup("post_reset_miss", 32'h0100_0050, 1'b0, 32'h0100_0054);

        $display("[TB] %0d tests run, %0d failed", testCount, failCount);
        $finish;
    end
endmodule

// File: doc/bpred_btb.md
Name: bpred_btb

Overview:
- Parametrised branch predictor for the fetch stage of the five-stage RV32I pipeline: a direct-mapped branch target buffer (BTB) with a saturating direction counter in each entry.
- Fetch presents its PC and receives a predicted next PC. Execute reports each resolved branch/jump, and the entry is trained on that report.
- Replaces the current always-not-taken fetch policy, so taken branches no longer pay the flush penalty on every execution.

Parameters:
- ADDR_WIDTH, 32, PC width in bits.
- ENTRIES, 64, number of BTB entries; must be a power of 2, minimum 2.
- CTR_BITS, 2, width of each saturating direction counter; minimum 1.
- Derived, not overridable: IDX_W = log2(ENTRIES); TAG_W = ADDR_WIDTH-2-IDX_W.

Ports:
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  synchronous, active-high reset.
- f_pc  in  ADDR_WIDTH  fetch-stage PC to look up.
- f_pred_taken  out  1  lookup hit and counter MSB = 1.
- f_pred_target  out  ADDR_WIDTH  predicted next PC.
- flush_all  in  1  invalidates every entry.
- upd_valid  in  1  execute is reporting one resolved control-flow instruction this cycle.
- upd_pc  in  ADDR_WIDTH  PC of the resolved instruction.
- upd_uncond  in  1  resolved instruction is jal/jalr.
- upd_taken  in  1  actual outcome.
- upd_target  in  ADDR_WIDTH  actual target (execute ALU result).
- upd_mispredict  in  1  execute detected a wrong direction or wrong target.
- stat_mispredicts  out  32  count of mispredict reports.

Behaviour:
- Address split: idx = pc[IDX_W+1:2]; tag = pc[ADDR_WIDTH-1:IDX_W+2]; pc[1:0] ignored.
- Per-entry state: valid (1 bit), tag (TAG_W), target (ADDR_WIDTH), ctr (CTR_BITS).
- Lookup is combinational, zero latency, from registered state:
  - hit = valid[idx] && tag[idx] == f_pc tag.
  - f_pred_taken = hit && ctr[idx][CTR_BITS-1].
  - f_pred_target = f_pred_taken ? target[idx] : f_pc+4, wrapping mod 2^ADDR_WIDTH.
- Update, at posedge when upd_valid=1 and flush_all=0; uhit = lookup hit computed on upd_pc:
  - uhit, conditional: ctr += 1 if upd_taken, saturating at 2^CTR_BITS-1; ctr -= 1 if not taken, saturating at 0. target <= upd_target only when upd_taken.
  - uhit, unconditional: ctr <= all ones; target <= upd_target.
  - Miss and upd_taken: allocate. valid <= 1, tag and target written, ctr <= 2^(CTR_BITS-1) (weakly taken), or all ones if upd_uncond. Any previous occupant of the index is overwritten.
  - Miss and not taken: no state change.
- stat_mispredicts increments by 1 on every cycle with upd_valid && upd_mispredict. Wraps from 0xFFFFFFFF to 0. Increments even when flush_all=1.
- flush_all clears all valid bits in one cycle. It has priority over an update in the same cycle; that update's entry write is dropped.
- Same-cycle lookup and update to the same idx: lookup returns the pre-update state; there is no bypass.
- Only one update per cycle; upd_valid is never asserted for a bubble/nop.
- rst:
  - All valid bits cleared, all ctr cleared to 0, stat_mispredicts = 0.
  - target/tag need no reset.
  - In the cycle after rst, f_pred_taken = 0 and f_pred_target = f_pc+4.
  - rst has priority over flush_all and update; reset mid-training discards all history.
- Integration: fetch uses f_pred_target as the next PC. Execute compares its resolution against the prediction carried down the pipe, drives upd_mispredict, and redirects on mismatch.

Test Plan (ENTRIES=64, CTR_BITS=2, ADDR_WIDTH=32):
1. Reset, then f_pc=0x01000010 -> f_pred_taken=0, f_pred_target=0x01000014; stat_mispredicts=0.
2. Allocate and train:
   - Update upd_pc=0x01000010, taken, target 0x01000000, mispredict=1 -> ctr=2, stat_mispredicts=1.
   - Next cycle, f_pc=0x01000010 -> f_pred_taken=1, f_pred_target=0x01000000.
3. Counter hysteresis:
   - From ctr=2, two taken updates -> ctr=3; a third taken holds at 3 (saturates).
   - One not-taken -> ctr=2; prediction still taken.
   - Second not-taken -> ctr=1; lookup returns taken=0, target=0x01000014.
4. Alias eviction: entry trained at 0x01000010; taken update at 0x01000110 (same idx 4, tag 0x010001) -> lookup at 0x01000010 misses (pred 0x01000014), lookup at 0x01000110 hits.
5. Same-cycle conflicts:
   - Lookup and taken update to the same cold idx -> f_pred_taken=0 that cycle, 1 the next.
   - flush_all together with an update -> all entries invalid next cycle, stat_mispredicts still increments.
6. Unconditional: jalr update at 0x01000020, target 0x01000400 on a miss -> ctr=3, so a single later not-taken report still predicts taken. 2^32 mispredict reports from reset -> stat_mispredicts wraps to 0.
